// File: rtl/decode_result_queue.sv
// In-order queue collecting decoded instructions from the format decoders and
// presenting the head entry downstream. Optional major-ID ordering check:
// define DECODE_QUEUE_ORDER_CHECK_EN.
module decode_result_queue #(
  parameter int unsigned NUM_DECODERS = 8,
  parameter int unsigned PAYLOAD_W    = 219,
  parameter int unsigned MAJID_W      = 64,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic [NUM_DECODERS-1:0]           valid_i,
  input  logic [NUM_DECODERS*PAYLOAD_W-1:0] payload_i,
  input  logic [NUM_DECODERS*MAJID_W-1:0]   majId_i,
  output logic                              stall_o,
  input  logic                              stall_i,
  output logic                              enable_o,
  output logic [PAYLOAD_W-1:0]              payload_o,
  output logic [MAJID_W-1:0]                majId_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic                              multiHit_o,
  output logic                              overflow_o,
  output logic                              orderError_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PAYLOAD_W-1:0] pay_mem [DEPTH];
  logic [MAJID_W-1:0]   id_mem  [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;

  logic [PAYLOAD_W-1:0] sel_payload;
  logic [MAJID_W-1:0]   sel_id;
  logic                 found;
  logic                 any_valid;
  logic                 multi;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 reject;

  // Lowest-index decoder wins; higher requests in the same cycle are dropped.
  always_comb begin
    sel_payload = '0;
    sel_id      = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < NUM_DECODERS; k++) begin
      if (valid_i[k] && !found) begin
        found       = 1'b1;
        sel_payload = payload_i[k*PAYLOAD_W +: PAYLOAD_W];
        sel_id      = majId_i[k*MAJID_W +: MAJID_W];
      end
    end
  end

  assign any_valid = |valid_i;
  assign multi     = |(valid_i & (valid_i - NUM_DECODERS'(1)));
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = enable_o && !stall_i;
  assign push      = any_valid && (!full || pop);
  assign reject    = any_valid && full && !pop;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      multiHit_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      multiHit_o <= multi;
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
        if (reject) overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && !flush_i && push) begin
      pay_mem[wr_ptr] <= sel_payload;
      id_mem[wr_ptr]  <= sel_id;
    end
  end

  assign enable_o  = (count != '0);
  assign payload_o = enable_o ? pay_mem[rd_ptr] : '0;
  assign majId_o   = enable_o ? id_mem[rd_ptr]  : '0;
  assign count_o   = count;
  assign stall_o   = (count >= CNT_W'(DEPTH - STALL_MARGIN));

`ifdef DECODE_QUEUE_ORDER_CHECK_EN
  logic [MAJID_W-1:0] last_id;
  logic               have_last;
  logic               order_error;

  // Flush forgets the last ID so the first push afterwards only reloads it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      last_id     <= '0;
      have_last   <= 1'b0;
      order_error <= 1'b0;
    end else if (flush_i) begin
      have_last <= 1'b0;
    end else if (push) begin
      if (have_last && (sel_id != last_id + MAJID_W'(1))) order_error <= 1'b1;
      last_id   <= sel_id;
      have_last <= 1'b1;
    end
  end

  assign orderError_o = order_error;
`else
  assign orderError_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_result_queue.sv
// Self-checking bench for decode_result_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_decode_result_queue;

  localparam int unsigned ND    = 8;
  localparam int unsigned PW    = 219;
  localparam int unsigned MW    = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SM    = 2;
`ifdef DECODE_QUEUE_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic              clk;
  logic              reset_i;
  logic              flush_i;
  logic [ND-1:0]     valid_i;
  logic [ND*PW-1:0]  payload_i;
  logic [ND*MW-1:0]  majId_i;
  logic              stall_o;
  logic              stall_i;
  logic              enable_o;
  logic [PW-1:0]     payload_o;
  logic [MW-1:0]     majId_o;
  logic [3:0]        count_o;
  logic              multiHit_o;
  logic              overflow_o;
  logic              orderError_o;

  typedef struct {
    logic [PW-1:0] pl;
    logic [MW-1:0] mj;
  } entry_t;

  entry_t        mq[$];
  bit            m_ovf, m_mh, m_oerr, m_have;
  logic [MW-1:0] m_last;
  int unsigned   n_checks, n_fail;

  decode_result_queue #(
    .NUM_DECODERS(ND), .PAYLOAD_W(PW), .MAJID_W(MW), .DEPTH(DEPTH), .STALL_MARGIN(SM)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i),
    .payload_i(payload_i), .majId_i(majId_i), .stall_o(stall_o), .stall_i(stall_i),
    .enable_o(enable_o), .payload_o(payload_o), .majId_o(majId_o), .count_o(count_o),
    .multiHit_o(multiHit_o), .overflow_o(overflow_o), .orderError_o(orderError_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[PW-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic drive_slot(input int k, input logic [PW-1:0] pl, input logic [MW-1:0] mj);
    payload_i[k*PW +: PW] = pl;
    majId_i[k*MW +: MW]   = mj;
  endtask

  function automatic logic [PW-1:0] exp_payload();
    return (mq.size() != 0) ? mq[0].pl : '0;
  endfunction

  function automatic logic [MW-1:0] exp_majid();
    return (mq.size() != 0) ? mq[0].mj : '0;
  endfunction

  // Reference model: apply this cycle's inputs, then advance one clock.
  task automatic step();
    bit     pop, accept;
    int     sel;
    entry_t e;
    pop = (mq.size() != 0) && !stall_i;
    if (reset_i) begin
      mq.delete();
      m_ovf = 0; m_mh = 0; m_oerr = 0; m_have = 0; m_last = '0;
    end else begin
      m_mh = ($countones(valid_i) > 1);
      if (flush_i) begin
        mq.delete();
        m_have = 0;
      end else begin
        sel = -1;
        for (int k = ND - 1; k >= 0; k--) if (valid_i[k]) sel = k;
        accept = (sel >= 0) && ((mq.size() < DEPTH) || pop);
        if (sel >= 0 && !accept) m_ovf = 1;
        if (pop) void'(mq.pop_front());
        if (accept) begin
          e.pl = payload_i[sel*PW +: PW];
          e.mj = majId_i[sel*MW +: MW];
          mq.push_back(e);
          if (ORDER_EN) begin
            if (m_have && e.mj != m_last + 64'd1) m_oerr = 1;
            m_last = e.mj;
            m_have = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = '0; flush_i = 0; stall_i = 0; reset_i = 1;
    step();
    reset_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1; flush_i = 1; stall_i = 0; valid_i = 8'b0011_0101;
    for (int k = 0; k < ND; k++) drive_slot(k, rand_payload(), 64'(k));
    step();
    reset_i = 0; flush_i = 0; valid_i = '0;
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_checks++; if (enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", enable_o); end
    n_checks++; if (payload_o !== '0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", payload_o); end
    n_checks++; if (majId_o !== '0) begin n_fail++; $display("FAIL reset_majid: got %h expected 0", majId_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    n_checks++; if (multiHit_o !== 1'b0) begin n_fail++; $display("FAIL reset_multihit: got %b expected 0", multiHit_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    n_checks++; if (orderError_o !== 1'b0) begin n_fail++; $display("FAIL reset_ordererr: got %b expected 0", orderError_o); end
  endtask

  task automatic test_single();
    logic [PW-1:0] pa;
    do_reset();
    pa = rand_payload();
    drive_slot(1, pa, 64'd5);
    valid_i = 8'b0000_0010;
    step();
    valid_i = '0;
    n_checks++; if (enable_o !== 1'b1) begin n_fail++; $display("FAIL single_enable: got %b expected 1", enable_o); end
    n_checks++; if (payload_o !== pa) begin n_fail++; $display("FAIL single_payload: got %h expected %h", payload_o, pa); end
    n_checks++; if (majId_o !== 64'd5) begin n_fail++; $display("FAIL single_majid: got %0d expected 5", majId_o); end
    n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count_o); end
    step();
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL single_drain_count: got %0d expected 0", count_o); end
    n_checks++; if (payload_o !== '0) begin n_fail++; $display("FAIL single_drain_payload: got %h expected 0", payload_o); end
  endtask

  task automatic test_fill_overflow();
    logic [PW-1:0] pl [9];
    int k;
    do_reset();
    stall_i = 1;
    for (int i = 0; i < 9; i++) begin
      k = $urandom_range(ND - 1);
      pl[i] = rand_payload();
      drive_slot(k, pl[i], 64'(i));
      valid_i = 8'(1 << k);
      step();
      n_checks++; if (count_o !== 4'(mq.size())) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, mq.size()); end
      n_checks++; if (stall_o !== (mq.size() >= DEPTH - SM)) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b expected %b", i, stall_o, mq.size() >= DEPTH - SM); end
      n_checks++; if (overflow_o !== (i == 8)) begin n_fail++; $display("FAIL fill_overflow[%0d]: got %b expected %b", i, overflow_o, i == 8); end
    end
    valid_i = '0;
    stall_i = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (majId_o !== 64'(i)) begin n_fail++; $display("FAIL drain_majid[%0d]: got %0d expected %0d", i, majId_o, i); end
      n_checks++; if (payload_o !== pl[i]) begin n_fail++; $display("FAIL drain_payload[%0d]: got %h expected %h", i, payload_o, pl[i]); end
      step();
    end
    n_checks++; if (enable_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", enable_o); end
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_multihit();
    logic [PW-1:0] p2, p6;
    do_reset();
    stall_i = 1;
    p2 = rand_payload(); p6 = rand_payload();
    drive_slot(2, p2, 64'd20);
    drive_slot(6, p6, 64'd21);
    valid_i = 8'b0100_0100;
    step();
    valid_i = '0;
    n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL mh_count: got %0d expected 1", count_o); end
    n_checks++; if (payload_o !== p2) begin n_fail++; $display("FAIL mh_payload: got %h expected %h", payload_o, p2); end
    n_checks++; if (majId_o !== 64'd20) begin n_fail++; $display("FAIL mh_majid: got %0d expected 20", majId_o); end
    n_checks++; if (multiHit_o !== 1'b1) begin n_fail++; $display("FAIL mh_pulse: got %b expected 1", multiHit_o); end
    step();
    n_checks++; if (multiHit_o !== 1'b0) begin n_fail++; $display("FAIL mh_pulse_end: got %b expected 0", multiHit_o); end
    n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL mh_dropped: got %0d expected 1", count_o); end
    stall_i = 0;
    step();
  endtask

  task automatic test_full_push_pop();
    logic [MW-1:0] want [$];
    int k;
    do_reset();
    stall_i = 1;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(ND - 1);
      drive_slot(k, rand_payload(), 64'(100 + i));
      valid_i = 8'(1 << k);
      step();
      if (i > 0) want.push_back(64'(100 + i));
    end
    stall_i = 0;
    k = $urandom_range(ND - 1);
    drive_slot(k, rand_payload(), 64'd200);
    valid_i = 8'(1 << k);
    want.push_back(64'd200);
    step();
    valid_i = '0;
    n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL fpp_count: got %0d expected 8", count_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %b expected 0", overflow_o); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (majId_o !== want[i]) begin n_fail++; $display("FAIL fpp_order[%0d]: got %0d expected %0d", i, majId_o, want[i]); end
      step();
    end
  endtask

  task automatic test_flush();
    do_reset();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive_slot(0, rand_payload(), 64'(i));
      valid_i = 8'b0000_0001;
      step();
    end
    n_checks++; if (count_o !== 4'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
    flush_i = 1;
    drive_slot(3, rand_payload(), 64'd3);
    valid_i = 8'b0000_1000;
    step();
    flush_i = 0; valid_i = '0;
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    n_checks++; if (enable_o !== 1'b0) begin n_fail++; $display("FAIL flush_enable: got %b expected 0", enable_o); end
    n_checks++; if (majId_o !== '0) begin n_fail++; $display("FAIL flush_majid: got %0d expected 0", majId_o); end
    for (int i = 0; i < 3; i++) begin
      drive_slot(0, rand_payload(), 64'(50 + i));
      drive_slot(5, rand_payload(), 64'(60 + i));
      valid_i = 8'b0010_0001;
      step();
    end
    reset_i = 1;
    step();
    reset_i = 0; valid_i = '0;
    n_checks++; if ({enable_o, count_o, stall_o, multiHit_o, overflow_o, orderError_o} !== '0)
      begin n_fail++; $display("FAIL burst_reset_flags: got %b expected 0", {enable_o, count_o, stall_o, multiHit_o, overflow_o, orderError_o}); end
    n_checks++; if (payload_o !== '0) begin n_fail++; $display("FAIL burst_reset_payload: got %h expected 0", payload_o); end
  endtask

  task automatic test_order();
    logic [MW-1:0] ids [3];
    do_reset();
    ids[0] = 64'd10; ids[1] = 64'd11; ids[2] = 64'd13;
    for (int i = 0; i < 3; i++) begin
      drive_slot(4, rand_payload(), ids[i]);
      valid_i = 8'b0001_0000;
      step();
`ifdef DECODE_QUEUE_ORDER_CHECK_EN
      n_checks++; if (orderError_o !== (i == 2)) begin n_fail++; $display("FAIL order_seq[%0d]: got %b expected %b", i, orderError_o, i == 2); end
`else
      n_checks++; if (orderError_o !== 1'b0) begin n_fail++; $display("FAIL order_tied[%0d]: got %b expected 0", i, orderError_o); end
`endif
    end
    valid_i = '0;
    do_reset();
    ids[0] = '1; ids[1] = '0;
    for (int i = 0; i < 2; i++) begin
      drive_slot(7, rand_payload(), ids[i]);
      valid_i = 8'b1000_0000;
      step();
      n_checks++; if (orderError_o !== 1'b0) begin n_fail++; $display("FAIL order_wrap[%0d]: got %b expected 0", i, orderError_o); end
    end
    valid_i = '0;
  endtask

  task automatic test_random();
    logic [MW-1:0] next_id;
    next_id = 64'($urandom);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset_i = ($urandom_range(199) == 0);
      flush_i = ($urandom_range(39) == 0);
      stall_i = ($urandom_range(2) == 0);
      valid_i = '0;
      if ($urandom_range(2) != 0) valid_i = 8'(1 << $urandom_range(ND - 1));
      if ($urandom_range(7) == 0) valid_i = valid_i | 8'($urandom);
      for (int k = 0; k < ND; k++)
        drive_slot(k, rand_payload(), ($urandom_range(30) == 0) ? 64'($urandom) : next_id);
      if (valid_i != '0) next_id = next_id + 64'd1;
      step();
      n_checks++; if (count_o !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, count_o, mq.size()); end
      n_checks++; if (enable_o !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_enable@%0d: got %b expected %b", c, enable_o, mq.size() != 0); end
      n_checks++; if (payload_o !== exp_payload()) begin n_fail++; $display("FAIL rnd_payload@%0d: got %h expected %h", c, payload_o, exp_payload()); end
      n_checks++; if (majId_o !== exp_majid()) begin n_fail++; $display("FAIL rnd_majid@%0d: got %h expected %h", c, majId_o, exp_majid()); end
      n_checks++; if (stall_o !== (mq.size() >= DEPTH - SM)) begin n_fail++; $display("FAIL rnd_stall@%0d: got %b expected %b", c, stall_o, mq.size() >= DEPTH - SM); end
      n_checks++; if (multiHit_o !== m_mh) begin n_fail++; $display("FAIL rnd_multihit@%0d: got %b expected %b", c, multiHit_o, m_mh); end
      n_checks++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b expected %b", c, overflow_o, m_ovf); end
      n_checks++; if (orderError_o !== m_oerr) begin n_fail++; $display("FAIL rnd_ordererr@%0d: got %b expected %b", c, orderError_o, m_oerr); end
    end
    reset_i = 0; flush_i = 0; valid_i = '0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_i = 0; flush_i = 0; stall_i = 0; valid_i = '0;
    payload_i = '0; majId_i = '0;
    m_last = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_multihit();
    test_full_push_pop();
    test_flush();
    test_order();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_result_queue.md
Name: decode_result_queue

Overview:
- Collects decoded instructions from the format-specific decoders (B, D, X, …; one valid per instruction) into an in-order queue.
- Presents queue entries to the downstream issue/rename stage through a valid/stall handshake.
- Back-pressures all format decoders through a shared stall, and flags protocol faults: multiple simultaneous hits, overflow and, optionally, major-ID ordering errors.

Parameters:
- NUM_DECODERS, 8, number of format-specific decoders feeding the queue.
- PAYLOAD_W, 219, width of one opaque decoded-instruction bundle (opcode, address, FU type, IDs, PID/TID, flags, body).
- MAJID_W, 64, instruction major-ID width.
- DEPTH, 8, queue entries; must be a power of 2 and at least 4.
- STALL_MARGIN, 2, free entries reserved for results already in flight when stall_o rises.

Ports:
- clock_i, input, 1, single clock; all state updates on the rising edge.
- reset_i, input, 1, synchronous, active-high reset.
- flush_i, input, 1, discard all queued entries.
- valid_i, input, NUM_DECODERS, per-decoder enable_o; bit k belongs to decoder k.
- payload_i, input, NUM_DECODERS*PAYLOAD_W, packed bundles; decoder k occupies slice k.
- majId_i, input, NUM_DECODERS*MAJID_W, packed major IDs; decoder k occupies slice k.
- stall_o, input-side, output, 1, stall to every format decoder.
- stall_i, input, 1, downstream stall.
- enable_o, output, 1, head entry valid.
- payload_o, output, PAYLOAD_W, head payload.
- majId_o, output, MAJID_W, head major ID.
- count_o, output, log2(DEPTH)+1, current occupancy.
- multiHit_o, output, 1, one-cycle pulse: more than one valid_i bit was set.
- overflow_o, output, 1, sticky: a push arrived while full.
- orderError_o, output, 1, sticky: major-ID sequence break (optional feature).

Behaviour:
- Reset (reset_i=1 at a clock edge): read/write pointers, count, multiHit_o, overflow_o, orderError_o and the last-ID tracker all clear.
  - enable_o=0, payload_o=0, majId_o=0, stall_o=0 from the next cycle.
  - Reset overrides flush, push and pop.
- Select: push source is the lowest set index of valid_i. If popcount(valid_i)>1, multiHit_o=1 for exactly the following cycle; the higher-index requests are dropped.
- Pop: occurs when enable_o=1 and stall_i=0; the read pointer advances at the edge.
- Push: accepted when any valid_i bit is set and (count<DEPTH, or a pop occurs in the same cycle).
  - An accepted push writes the selected payload and majId at the write pointer, which then advances.
  - A rejected push sets overflow_o (sticky until reset) and drops the data.
- Simultaneous push and pop: both take effect and count is unchanged. Full+pop+push is legal; empty+push with no pop is a plain push.
- Latency: a push accepted at edge N gives enable_o=1 with its data in the cycle after edge N. There is no same-cycle bypass from valid_i to enable_o.
- Output data:
  - Head is shown ahead (first-word fall-through) from the registered array.
  - enable_o=(count!=0).
  - payload_o and majId_o are forced to 0 while enable_o=0.
  - Head data holds stable while stall_i=1.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; count_o=DEPTH means full.
- stall_o=(count >= DEPTH-STALL_MARGIN), decoded from the count register only; it is not combinational from valid_i.
- flush_i=1: at the edge, pointers and count go to 0 and any push or pop that cycle is ignored. overflow_o and orderError_o are not cleared; multiHit_o detection still applies.
- Order is strictly FIFO; there is no reordering by major ID.

Optional Feature:
- Macro: DECODE_QUEUE_ORDER_CHECK_EN.
- Defined:
  - On every accepted push, compare the pushed majId against lastMajId+1, with modulo 2^MAJID_W wrap.
  - A mismatch sets orderError_o (sticky until reset).
  - The first push after reset or flush only loads lastMajId and never flags.
  - A dropped push is not checked.
- Undefined: orderError_o is tied to 0 and no tracker register exists.

Test Plan:
- Reset, then valid_i=8'b0000_0010 with payload A, majId 5 for one cycle, stall_i=0 → enable_o=1 the next cycle with payload A and majId_o=5; count_o returns to 0 the cycle after.
- stall_i=1; push 6 entries with majId 0..5 → stall_o=1 once count_o=6. Push 2 more → count_o=8. Push a 9th → overflow_o=1 and the 9th is lost. Release stall_i → outputs 0..7 in order, one per cycle.
- valid_i=8'b0100_0100 in one cycle → the decoder-2 payload is queued, the decoder-6 payload is dropped, multiHit_o=1 for exactly one cycle.
- Queue full (8 entries), stall_i=0, push in the same cycle → pop and push both occur, count_o stays 8, overflow_o stays 0.
- Queue holds 3 entries; flush_i=1 with a simultaneous push → the next cycle has count_o=0 and enable_o=0, and the push is discarded. Assert reset_i mid-burst → all outputs 0 the next cycle.
- With DECODE_QUEUE_ORDER_CHECK_EN: push majIds 10, 11, 13 → orderError_o=1 after the third push. After reset, push 2^64-1 then 0 → orderError_o stays 0.
